reg_bank: RTL and testbench

//  - 32-entry x 32-bit general-purpose register file for the multicycle MIPS datapath.
//  - Sits directly downstream of the register-destination mux; write_reg is that mux's 5-bit output.
//  - Two combinational read ports feed the A/B operand latches, which are also held in this block.
//  - A single write port is committed on the clock edge.

---
 rtl/reg_bank.sv | 54 +++++
 tb/tb_reg_bank.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank: 32x32 MIPS register file with two combinational read ports,
// optional same-cycle write forwarding, and registered A/B operand latches.
module reg_bank #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(227),
    parameter bit                 BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic              load_ab,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out
);
    logic [DATA_W-1:0] r_regs [32];
    logic              w_we;
    logic              w_byp1;
    logic              w_byp2;

    assign w_we   = reg_write && (write_reg != 5'd0);
    assign w_byp1 = BYPASS && w_we && (write_reg == read_reg1);
    assign w_byp2 = BYPASS && w_we && (write_reg == read_reg2);

    always_comb begin
        read_data1 = (read_reg1 == 5'd0) ? '0 : w_byp1 ? write_data : r_regs[read_reg1];
        read_data2 = (read_reg2 == 5'd0) ? '0 : w_byp2 ? write_data : r_regs[read_reg2];
    end

    // $0 is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= (i == 29) ? SP_RESET : '0;
        end else if (w_we) begin
            r_regs[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_out <= '0;
            b_out <= '0;
        end else if (load_ab) begin
            a_out <= read_data1;
            b_out <= read_data2;
        end
    end
endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: checks a forwarding and a non-forwarding reg_bank instance
// side by side against an array-based reference model.
module tb_reg_bank;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        reg_write = 1'b0;
    logic        load_ab = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic [31:0] write_data = '0;
    logic [1:0][31:0] rd1, rd2, a, b;

    int errors = 0;
    int checks = 0;
    logic [31:0] m [32];
    logic [31:0] ma [2];
    logic [31:0] mb [2];

    reg_bank #(.BYPASS(1'b0)) u_nobyp (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .load_ab(load_ab), .read_data1(rd1[0]), .read_data2(rd2[0]),
        .a_out(a[0]), .b_out(b[0]));

    reg_bank #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .load_ab(load_ab), .read_data1(rd1[1]), .read_data2(rd2[1]),
        .a_out(a[1]), .b_out(b[1]));

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input int v, input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (v == 1 && reg_write && write_reg != 5'd0 && write_reg == idx) return write_data;
        return m[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        for (int v = 0; v < 2; v++) begin
            chk($sformatf("rd1[byp=%0d]", v), rd1[v], exp_rd(v, read_reg1));
            chk($sformatf("rd2[byp=%0d]", v), rd2[v], exp_rd(v, read_reg2));
            chk($sformatf("a[byp=%0d]", v), a[v], ma[v]);
            chk($sformatf("b[byp=%0d]", v), b[v], mb[v]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = (i == 29) ? 32'd227 : 32'd0;
        for (int v = 0; v < 2; v++) begin
            ma[v] = '0;
            mb[v] = '0;
        end
    endtask

    task automatic model_edge();
        for (int v = 0; v < 2; v++)
            if (load_ab) begin
                ma[v] = exp_rd(v, read_reg1);
                mb[v] = exp_rd(v, read_reg2);
            end
        if (reg_write && write_reg != 5'd0) m[write_reg] = write_data;
    endtask

    // drive one cycle's inputs, check before the edge, then advance the model past it
    task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic ld);
        @(negedge clk);
        reg_write = we; write_reg = wr; write_data = wd;
        read_reg1 = r1; read_reg2 = r2; load_ab = ld;
        #1;
        check_all();
        model_edge();
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("init_sp", u_byp.read_data1, 32'd0);
        read_reg1 = 5'd29; read_reg2 = 5'd5;
        #1;
        chk("init_rd29", rd1[1], 32'd227);
        chk("init_rd5", rd2[1], 32'd0);
        check_all();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        step(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd9, 1'b0);
        step(1'b0, 5'd0, 32'd0, 5'd8, 5'd9, 1'b0);
        chk("wr8_rd", rd1[0], 32'hDEADBEEF);
        chk("wr8_rd9", rd2[0], 32'd0);

        step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        chk("zero_rd1", rd1[1], 32'd0);
        chk("zero_rd2", rd2[0], 32'd0);

        step(1'b1, 5'd31, 32'h00400010, 5'd0, 5'd31, 1'b1);
        chk("byp_rd2", rd2[1], 32'h00400010);
        chk("nobyp_rd2", rd2[0], 32'd0);
        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd31, 1'b0);
        chk("byp_b", b[1], 32'h00400010);
        chk("nobyp_b", b[0], 32'd0);
        chk("nobyp_rd2_after", rd2[0], 32'h00400010);

        for (int n = 0; n < 10000; n++) begin
            logic [4:0] wr, r1, r2;
            wr = 5'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
            step(1'($urandom_range(0, 1)), wr, $urandom, r1, r2, 1'($urandom_range(0, 1)));
        end
        step(1'b1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd5, 1'b1);

        // asynchronous reset mid-cycle, no clock edge in between
        @(negedge clk);
        reg_write = 1'b0; load_ab = 1'b0; read_reg1 = 5'd29; read_reg2 = 5'd5;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rd29", rd1[1], 32'd227);
        chk("async_rd5", rd2[0], 32'd0);
        chk("async_a", a[1], 32'd0);
        chk("async_b", b[0], 32'd0);
        model_reset();
        check_all();

        // write and load while reset is held across an edge
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd29; write_data = 32'hFF; load_ab = 1'b1;
        @(posedge clk);
        #1;
        reg_write = 1'b0; load_ab = 1'b0;
        #1;
        chk("rst_hold_rd29", rd1[0], 32'd227);
        chk("rst_hold_a", a[1], 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 5'd0, 32'd0, 5'd29, 5'd0, 1'b0);
        chk("rst_rel_rd29", rd1[1], 32'd227);
        chk("rst_rel_a", a[0], 32'd0);
        step(1'b1, 5'd29, 32'h55, 5'd29, 5'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0, 5'd29, 5'd0, 1'b0);
        chk("post_rst_wr29", rd1[0], 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
